// File: rtl/mem_status_poller_multi.sv
// Flash status poller: counts SPI transfers to a programmed total,
// then polls Read-Status until the flash reports idle or the limit hits.
module mem_status_poller_multi #(
    parameter int                CNT_W     = 8,
    parameter int                STAT_W    = 8,
    parameter logic [STAT_W-1:0] BUSY_MASK = STAT_W'(1),
    parameter int                POLL_GAP  = 4,
    parameter int                LIMIT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   in_total_transfers,
    input  logic [LIMIT_W-1:0] in_poll_limit,
    input  logic               in_poller_start,
    input  logic               in_xfer_done,
    output logic               out_spi_req_valid,
    input  logic               in_spi_req_ready,
    input  logic               in_spi_rsp_valid,
    input  logic [STAT_W-1:0]  in_spi_rsp_data,
    output logic               out_ready,
    output logic               out_done,
    output logic [CNT_W-1:0]   out_completed,
    output logic [STAT_W-1:0]  out_status,
    output logic [5:0]         out_flags
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_ISSUE,
        S_WAIT_RSP,
        S_GAP,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_total;
    logic [LIMIT_W-1:0] r_limit;
    logic [CNT_W-1:0]   r_completed;
    logic [LIMIT_W-1:0] r_poll_cnt;
    logic [STAT_W-1:0]  r_status;
    logic [4:0]         r_flags;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_busy;
    logic               w_timeout;
    logic               w_gap_last;
    logic               w_polling;

    assign w_cnt_inc  = r_completed + CNT_W'(1);
    assign w_busy     = (in_spi_rsp_data & BUSY_MASK) != '0;
    assign w_timeout  = (r_limit != '0) && (r_poll_cnt >= r_limit);
    assign w_gap_last = r_gap_cnt == GAP_W'(POLL_GAP - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next            = r_state;
        out_ready         = 1'b0;
        out_spi_req_valid = 1'b0;
        out_done          = 1'b0;
        w_polling         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                out_ready = 1'b1;
                if (in_poller_start)
                    w_next = (in_total_transfers == '0) ? S_ISSUE : S_COUNT;
            end
            S_COUNT: begin
                if (in_xfer_done && (w_cnt_inc == r_total))
                    w_next = S_ISSUE;
            end
            S_ISSUE: begin
                out_spi_req_valid = 1'b1;
                w_polling         = 1'b1;
                if (in_spi_req_ready)
                    w_next = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                w_polling = 1'b1;
                if (in_spi_rsp_valid) begin
                    if (!w_busy || w_timeout) w_next = S_DONE;
                    else                      w_next = S_GAP;
                end
            end
            S_GAP: begin
                w_polling = 1'b1;
                if (w_gap_last)
                    w_next = S_ISSUE;
            end
            S_DONE: begin
                out_done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total     <= '0;
            r_limit     <= '0;
            r_completed <= '0;
            r_poll_cnt  <= '0;
            r_status    <= '0;
            r_flags     <= '0;
            r_gap_cnt   <= '0;
        end else begin
            if (in_xfer_done && (r_state != S_COUNT))
                r_flags[3] <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (in_poller_start) begin
                        r_total     <= in_total_transfers;
                        r_limit     <= in_poll_limit;
                        r_completed <= '0;
                        r_poll_cnt  <= '0;
                        r_flags     <= {in_total_transfers == '0, 4'b0000};
                    end
                end
                S_COUNT: begin
                    if (in_xfer_done) begin
                        r_completed <= w_cnt_inc;
                        if (w_cnt_inc == r_total)
                            r_flags[0] <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (in_spi_req_ready && (r_poll_cnt != '1))
                        r_poll_cnt <= r_poll_cnt + LIMIT_W'(1);
                end
                S_WAIT_RSP: begin
                    r_gap_cnt <= '0;
                    if (in_spi_rsp_valid) begin
                        r_status <= in_spi_rsp_data;
                        if (w_busy) begin
                            r_flags[1] <= 1'b1;
                            if (w_timeout)
                                r_flags[2] <= 1'b1;
                        end
                    end
                end
                S_GAP:   r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                S_DONE:  ;
                default: ;
            endcase
        end
    end

    assign out_completed = r_completed;
    assign out_status    = r_status;
    assign out_flags     = {w_polling, r_flags};

endmodule

// File: tb/tb_mem_status_poller_multi.sv
// Directed bench for mem_status_poller_multi: counting, polling,
// gap timing, poll limit, stalls, ignored restarts and async reset.
module tb_mem_status_poller_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_total_transfers = '0;
    logic [15:0] in_poll_limit = '0;
    logic        in_poller_start = 1'b0;
    logic        in_xfer_done = 1'b0;
    logic        out_spi_req_valid;
    logic        in_spi_req_ready = 1'b0;
    logic        in_spi_rsp_valid = 1'b0;
    logic [7:0]  in_spi_rsp_data = '0;
    logic        out_ready;
    logic        out_done;
    logic [7:0]  out_completed;
    logic [7:0]  out_status;
    logic [5:0]  out_flags;

    int checks = 0;
    int errors = 0;

    mem_status_poller_multi dut (
        .clk                (clk),
        .rst                (rst),
        .in_total_transfers (in_total_transfers),
        .in_poll_limit      (in_poll_limit),
        .in_poller_start    (in_poller_start),
        .in_xfer_done       (in_xfer_done),
        .out_spi_req_valid  (out_spi_req_valid),
        .in_spi_req_ready   (in_spi_req_ready),
        .in_spi_rsp_valid   (in_spi_rsp_valid),
        .in_spi_rsp_data    (in_spi_rsp_data),
        .out_ready          (out_ready),
        .out_done           (out_done),
        .out_completed      (out_completed),
        .out_status         (out_status),
        .out_flags          (out_flags)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] tot, input logic [15:0] lim);
        in_total_transfers = tot;
        in_poll_limit      = lim;
        in_poller_start    = 1'b1;
        tick();
        in_poller_start    = 1'b0;
    endtask

    task automatic pulse_xfer;
        in_xfer_done = 1'b1;
        tick();
        in_xfer_done = 1'b0;
    endtask

    // Waits for a request, accepts it, then returns one response.
    task automatic poll_once(input logic [7:0] d, output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        while (!out_spi_req_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_spi_req_valid) begin
            to = 1'b1;
            return;
        end
        in_spi_req_ready = 1'b1;
        tick();
        in_spi_req_ready = 1'b0;
        in_spi_rsp_valid = 1'b1;
        in_spi_rsp_data  = d;
        tick();
        in_spi_rsp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        checks++;
        if ({out_ready, out_spi_req_valid, out_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=100",
                     {out_ready, out_spi_req_valid, out_done});
        end
        checks++;
        if (out_completed !== 8'h00 || out_status !== 8'h00 || out_flags !== 6'b0) begin
            errors++;
            $display("FAIL reset_regs got=%h/%h/%b exp=00/00/000000",
                     out_completed, out_status, out_flags);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        bit to;
        start(8'd3, 16'd0);
        checks++;
        if (out_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got=%b exp=0", out_ready);
        end
        pulse_xfer();
        pulse_xfer();
        checks++;
        if (out_spi_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_req got=%b exp=0", out_spi_req_valid);
        end
        pulse_xfer();
        checks++;
        if (out_spi_req_valid !== 1'b1 || out_completed !== 8'd3) begin
            errors++;
            $display("FAIL basic_req got=%b/%0d exp=1/3",
                     out_spi_req_valid, out_completed);
        end
        poll_once(8'h00, to);
        checks++;
        if (to || out_done !== 1'b1 || out_flags !== 6'b000001) begin
            errors++;
            $display("FAIL basic_done got=%b/%b exp=1/000001", out_done, out_flags);
        end
        tick();
        checks++;
        if (out_done !== 1'b0 || out_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle got=%b/%b exp=0/1", out_done, out_ready);
        end
        pulse_xfer();
        checks++;
        if (out_flags !== 6'b001001 || out_completed !== 8'd3) begin
            errors++;
            $display("FAIL basic_ovf_idle got=%b/%0d exp=001001/3",
                     out_flags, out_completed);
        end
    endtask

    task automatic test_busy_gap;
        bit         to;
        int         gap;
        int         reqs;
        logic [7:0] rsp [3];
        rsp[0] = 8'h01;
        rsp[1] = 8'h01;
        rsp[2] = 8'h00;
        reqs = 0;
        start(8'd2, 16'd0);
        pulse_xfer();
        pulse_xfer();
        for (int i = 0; i < 3; i++) begin
            poll_once(rsp[i], to);
            if (to) break;
            reqs++;
            if (i < 2) begin
                checks++;
                if (out_flags[5] !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_active got=%b exp=1", out_flags[5]);
                end
                gap = 0;
                while (!out_spi_req_valid && gap < 20) begin
                    gap++;
                    tick();
                end
                checks++;
                if (gap != 4) begin
                    errors++;
                    $display("FAIL gap_len%0d got=%0d exp=4", i, gap);
                end
            end
        end
        checks++;
        if (reqs != 3 || out_done !== 1'b1) begin
            errors++;
            $display("FAIL gap_reqs got=%0d/%b exp=3/1", reqs, out_done);
        end
        checks++;
        if (out_flags !== 6'b000011 || out_status !== 8'h00) begin
            errors++;
            $display("FAIL gap_flags got=%b/%h exp=000011/00", out_flags, out_status);
        end
        tick();
    endtask

    task automatic test_timeout;
        bit to;
        int reqs;
        reqs = 0;
        start(8'd1, 16'd2);
        pulse_xfer();
        for (int i = 0; i < 4; i++) begin
            poll_once(8'h03, to);
            if (to) break;
            reqs++;
            if (out_done) break;
        end
        checks++;
        if (reqs != 2 || out_done !== 1'b1) begin
            errors++;
            $display("FAIL tmo_reqs got=%0d/%b exp=2/1", reqs, out_done);
        end
        checks++;
        if (out_flags !== 6'b000111 || out_status !== 8'h03) begin
            errors++;
            $display("FAIL tmo_flags got=%b/%h exp=000111/03", out_flags, out_status);
        end
        tick();
    endtask

    task automatic test_zero_total;
        bit to;
        start(8'd0, 16'd0);
        checks++;
        if (out_spi_req_valid !== 1'b1 || out_flags !== 6'b110000) begin
            errors++;
            $display("FAIL zero_req got=%b/%b exp=1/110000",
                     out_spi_req_valid, out_flags);
        end
        pulse_xfer();
        checks++;
        if (out_flags !== 6'b111000 || out_completed !== 8'd0) begin
            errors++;
            $display("FAIL zero_ovf got=%b/%0d exp=111000/0", out_flags, out_completed);
        end
        poll_once(8'h00, to);
        checks++;
        if (to || out_done !== 1'b1 || out_flags !== 6'b011000) begin
            errors++;
            $display("FAIL zero_done got=%b/%b exp=1/011000", out_done, out_flags);
        end
        tick();
    endtask

    task automatic test_stall_restart;
        bit to;
        bit held;
        held = 1'b1;
        start(8'd1, 16'd2);
        pulse_xfer();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_total_transfers = 8'd7;
                in_poller_start    = 1'b1;
            end
            tick();
            in_poller_start = 1'b0;
            if (out_spi_req_valid !== 1'b1 || out_ready !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL stall_hold got=%b/%b exp=1/0", out_spi_req_valid, out_ready);
        end
        checks++;
        if (out_completed !== 8'd1) begin
            errors++;
            $display("FAIL restart_ignored got=%0d exp=1", out_completed);
        end
        poll_once(8'h01, to);
        checks++;
        if (to || out_done !== 1'b0 || out_flags !== 6'b100011) begin
            errors++;
            $display("FAIL stall_pollcnt got=%b/%b exp=0/100011", out_done, out_flags);
        end
        poll_once(8'h00, to);
        checks++;
        if (to || out_done !== 1'b1 || out_flags !== 6'b000011) begin
            errors++;
            $display("FAIL stall_done got=%b/%b exp=1/000011", out_done, out_flags);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        saw_done = 1'b0;
        start(8'd0, 16'd0);
        in_spi_req_ready = 1'b1;
        tick();
        in_spi_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_ready !== 1'b1 || out_spi_req_valid !== 1'b0 || out_flags !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid got=%b/%b/%b exp=1/0/000000",
                     out_ready, out_spi_req_valid, out_flags);
        end
        tick();
        rst = 1'b0;
        in_spi_rsp_valid = 1'b1;
        in_spi_rsp_data  = 8'h55;
        tick();
        in_spi_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_done) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done || out_status !== 8'h00 || out_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_late_rsp got=%b/%h/%b exp=0/00/1",
                     saw_done, out_status, out_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_gap();
        test_timeout();
        test_zero_total();
        test_stall_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
